// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type, S-box table and byte-level helpers
// for the iterative round sequencer.
`timescale 1ns/1ps
package aes_pkg;

    localparam int unsigned NR      = 10;
    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned RIDX_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } seq_state_e;

    // Forward S-box, indexed by input byte value.
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox_byte(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Round constant for rounds 1..10; zero outside that range.
    function automatic logic [7:0] rcon_lookup(input logic [RIDX_W-1:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One step of the AES-128 key schedule: next round key from the current one.
`timescale 1ns/1ps
module aes_key_step
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] rk,
    input  logic [7:0]         rcon,
    output logic [BLOCK_W-1:0] nk
);

    logic [WORD_W-1:0] w3;
    logic [WORD_W-1:0] t;
    logic [WORD_W-1:0] w0n, w1n, w2n, w3n;

    assign w3 = rk[WORD_W-1:0];

    // SubWord(RotWord(w3)) ^ {rcon, 0, 0, 0}
    assign t = {sbox_byte(w3[23:16]), sbox_byte(w3[15:8]),
                sbox_byte(w3[7:0]),   sbox_byte(w3[31:24])} ^ {rcon, 24'h000000};

    assign w0n = rk[127:96] ^ t;
    assign w1n = rk[95:64]  ^ w0n;
    assign w2n = rk[63:32]  ^ w1n;
    assign w3n = rk[31:0]   ^ w2n;

    assign nk = {w0n, w1n, w2n, w3n};

endmodule

// File: rtl/columnMix.sv
// MixColumns: each 32-bit column multiplied by the fixed {02,03,01,01} circulant.
`timescale 1ns/1ps
module columnMix
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] data_i,
    output logic [BLOCK_W-1:0] data_o
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [BYTE_W-1:0] a0, a1, a2, a3;

        assign a0 = data_i[BLOCK_W-1-WORD_W*c             -: BYTE_W];
        assign a1 = data_i[BLOCK_W-1-WORD_W*c-BYTE_W      -: BYTE_W];
        assign a2 = data_i[BLOCK_W-1-WORD_W*c-2*BYTE_W    -: BYTE_W];
        assign a3 = data_i[BLOCK_W-1-WORD_W*c-3*BYTE_W    -: BYTE_W];

        assign data_o[BLOCK_W-1-WORD_W*c          -: BYTE_W] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign data_o[BLOCK_W-1-WORD_W*c-BYTE_W   -: BYTE_W] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign data_o[BLOCK_W-1-WORD_W*c-2*BYTE_W -: BYTE_W] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign data_o[BLOCK_W-1-WORD_W*c-3*BYTE_W -: BYTE_W] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

endmodule

// File: rtl/rowShift.sv
// ShiftRows: byte (row r, column c) takes the byte from column (c+r) mod 4.
`timescale 1ns/1ps
module rowShift
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] data_i,
    output logic [BLOCK_W-1:0] data_o
);

    // State bytes are column-major: byte index = 4*column + row.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign data_o[BLOCK_W-1-BYTE_W*(4*c+r) -: BYTE_W] =
                data_i[BLOCK_W-1-BYTE_W*(4*((c+r)%4)+r) -: BYTE_W];
        end
    end

endmodule

// File: rtl/sbox.sv
// SubBytes over a full 128-bit state.
`timescale 1ns/1ps
module sbox
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] data_i,
    output logic [BLOCK_W-1:0] data_o
);

    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign data_o[BLOCK_W-1-BYTE_W*i -: BYTE_W] = sbox_byte(data_i[BLOCK_W-1-BYTE_W*i -: BYTE_W]);
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryptor: one shared round datapath and on-the-fly key
// schedule, with valid/ready handshakes on input and output.
`timescale 1ns/1ps
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int unsigned NR = aes_pkg::NR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] plain_text,
    input  logic [BLOCK_W-1:0] key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] cipher_text,
    output logic               busy,
    output logic [RIDX_W-1:0]  round_idx
);

    if (NR != 10) begin : g_nr_check
        $error("aes_round_sequencer: only NR=10 (AES-128) is supported");
    end

    seq_state_e         state_q, state_d;
    logic [BLOCK_W-1:0] st_q, st_d;
    logic [BLOCK_W-1:0] rk_q, rk_d;
    logic [RIDX_W-1:0]  ridx_q, ridx_d;

    logic [BLOCK_W-1:0] sb_out, sr_out, mc_out, nk;
    logic [7:0]         rcon_c;
    logic               last_round_c;
    logic               accept_c;

    sbox u_sbox (
        .data_i (st_q),
        .data_o (sb_out)
    );

    rowShift u_row_shift (
        .data_i (sb_out),
        .data_o (sr_out)
    );

    columnMix u_column_mix (
        .data_i (sr_out),
        .data_o (mc_out)
    );

    assign rcon_c = rcon_lookup(ridx_q);

    aes_key_step u_key_step (
        .rk   (rk_q),
        .rcon (rcon_c),
        .nk   (nk)
    );

    assign last_round_c = (ridx_q == RIDX_W'(NR));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            st_q    <= '0;
            rk_q    <= '0;
            ridx_q  <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            rk_q    <= rk_d;
            ridx_q  <= ridx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        st_d     = st_q;
        rk_d     = rk_q;
        ridx_d   = ridx_q;
        in_ready = 1'b0;
        accept_c = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                accept_c = in_valid;
            end
            ROUND: begin
                rk_d = nk;
                // Final round skips MixColumns.
                if (last_round_c) begin
                    st_d    = sr_out ^ nk;
                    ridx_d  = '0;
                    state_d = DONE;
                end else begin
                    st_d   = mc_out ^ nk;
                    ridx_d = ridx_q + RIDX_W'(1);
                end
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    accept_c = in_valid;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Accepting a block overrides DONE->IDLE so a drain and load share one edge.
        if (accept_c) begin
            st_d    = plain_text ^ key;
            rk_d    = key;
            ridx_d  = RIDX_W'(1);
            state_d = ROUND;
        end
    end

    assign out_valid   = (state_q == DONE);
    assign busy        = (state_q == ROUND);
    assign cipher_text = st_q;
    assign round_idx   = ridx_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: directed FIPS-197 vectors plus
// randomized traffic, checked every cycle against a byte-array AES model.
`timescale 1ns/1ps
module tb_aes_round_sequencer;

    logic         clk        = 1'b0;
    logic         rst        = 1'b0;
    logic         in_valid   = 1'b0;
    logic         out_ready  = 1'b0;
    logic [127:0] plain_text = '0;
    logic [127:0] key        = '0;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic [127:0] cipher_text;
    logic [3:0]   round_idx;

    aes_round_sequencer #(.NR(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .plain_text  (plain_text),
        .key         (key),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .cipher_text (cipher_text),
        .busy        (busy),
        .round_idx   (round_idx)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] P1    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K1    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P2    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K2    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] RK2_1 = 128'ha0fafe1788542cb123a339392a6c7605;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] sb [256];

    // Reference model: phase 0 idle, 1 computing, 2 result waiting.
    int           m_phase = 0;
    int           m_round = 0;
    logic [127:0] m_ct    = '0;

    int cyc   = 0;
    int n_acc = 0;
    int n_out = 0;
    int out_cycs [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] xb  = 8'(x);
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc = 8'h01;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++)
                    t[4*c+q] = sb[s[4*((c+q)%4)+q]];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++)
                    if (r < 10)
                        s[4*c+q] = gmul(8'h02, t[4*c+q]) ^ gmul(8'h03, t[4*c+(q+1)%4]) ^
                                   t[4*c+(q+2)%4] ^ t[4*c+(q+3)%4];
                    else
                        s[4*c+q] = t[4*c+q];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            m_round = 0;
        end else begin
            bit acc;
            acc = in_valid && (m_phase == 0 || (m_phase == 2 && out_ready));
            if (m_phase == 1) begin
                if (m_round == 10) begin
                    m_phase = 2;
                    m_round = 0;
                end else begin
                    m_round++;
                end
            end else if (m_phase == 2 && out_ready && !acc) begin
                m_phase = 0;
            end
            if (acc) begin
                m_phase = 1;
                m_round = 1;
                m_ct    = aes_enc(plain_text, key);
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            cyc++;
            if (in_valid && in_ready) n_acc++;
            if (out_valid && out_ready) begin
                n_out++;
                out_cycs.push_back(cyc);
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        check("cyc_in_ready",  in_ready,  (m_phase == 0 || (m_phase == 2 && out_ready)));
        check("cyc_out_valid", out_valid, (m_phase == 2));
        check("cyc_busy",      busy,      (m_phase == 1));
        check("cyc_round_idx", round_idx, 128'(m_round));
        if (m_phase == 2) check("cyc_cipher_text", cipher_text, m_ct);
    end

    task automatic send(input logic [127:0] p, input logic [127:0] k, input bit drop);
        int w = 0;
        in_valid   = 1'b1;
        plain_text = p;
        key        = k;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) check("send_timeout", 128'(0), 128'(1));
        @(posedge clk);
        #1;
        if (drop) in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) check("out_timeout", 128'(0), 128'(1));
    endtask

    initial begin
        int lat;
        int acc0, out0, w;

        build_sbox();
        check("model_sbox_00", sb[8'h00], 8'h63);
        check("model_sbox_53", sb[8'h53], 8'hed);
        check("model_vec1", aes_enc(P1, K1), C1);
        check("model_vec2", aes_enc(P2, K2), C2);

        #1 rst = 1'b1;
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_round_idx", round_idx, 0);
        check("rst_cipher_text", cipher_text, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 1: basic vector, latency and single-cycle pulse
        out_ready = 1'b1;
        send(P1, K1, 1);
        wait_out(lat);
        check("t1_latency", 128'(lat), 10);
        check("t1_ct", cipher_text, C1);
        @(posedge clk); #1;
        check("t1_pulse", out_valid, 0);

        // 2: second vector and first-round key
        send(P2, K2, 1);
        @(posedge clk); #1;
        check("t2_rk1", dut.rk_q, RK2_1);
        check("t2_round_idx", round_idx, 2);
        wait_out(lat);
        check("t2_ct", cipher_text, C2);
        @(posedge clk); #1;

        // 3: backpressure then same-cycle drain and load
        out_ready = 1'b0;
        send(P1, K1, 1);
        wait_out(lat);
        out0 = n_out;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("t3_hold_valid", out_valid, 1);
            check("t3_hold_ct", cipher_text, C1);
            check("t3_hold_in_ready", in_ready, 0);
        end
        check("t3_no_drain", 128'(n_out - out0), 0);
        out_ready = 1'b1;
        send(P2, K2, 1);
        wait_out(lat);
        check("t3_latency", 128'(lat), 10);
        check("t3_ct", cipher_text, C2);
        @(posedge clk); #1;

        // 4: streaming, 8 alternating blocks
        acc0 = n_acc;
        out0 = n_out;
        out_cycs.delete();
        for (int b = 0; b < 8; b++) begin
            if (b % 2 == 0) send(P1, K1, 0);
            else            send(P2, K2, 0);
        end
        in_valid = 1'b0;
        wait_out(lat);
        @(posedge clk); #1;
        check("t4_accepts", 128'(n_acc - acc0), 8);
        check("t4_outputs", 128'(n_out - out0), 8);
        for (int i = 1; i < out_cycs.size(); i++)
            check("t4_spacing", 128'(out_cycs[i] - out_cycs[i-1]), 11);

        // 5: asynchronous reset mid-computation
        send(P1, K1, 1);
        w = 0;
        while (round_idx != 4'd5 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("t5_reached_r5", round_idx, 5);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_out_valid", out_valid, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_round_idx", round_idx, 0);
        check("t5_rst_in_ready", in_ready, 1);
        check("t5_rst_ct", cipher_text, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        out0 = n_out;
        repeat (15) @(posedge clk);
        #1;
        check("t5_no_output", 128'(n_out - out0), 0);
        send(P2, K2, 1);
        wait_out(lat);
        check("t5_ct", cipher_text, C2);
        @(posedge clk); #1;

        // 6: input churn while computing
        out_ready = 1'b0;
        acc0 = n_acc;
        send(P1, K1, 1);
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            in_valid   = 1'($urandom_range(0, 1));
            plain_text = {$urandom, $urandom, $urandom, $urandom};
            key        = {$urandom, $urandom, $urandom, $urandom};
        end
        in_valid = 1'b0;
        check("t6_accepts", 128'(n_acc - acc0), 1);
        check("t6_valid", out_valid, 1);
        check("t6_ct", cipher_text, C1);
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic checked by the per-cycle model compare
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            in_valid   = 1'($urandom_range(0, 1));
            out_ready  = ($urandom_range(0, 3) != 0);
            plain_text = {$urandom, $urandom, $urandom, $urandom};
            key        = {$urandom, $urandom, $urandom, $urandom};
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("end_idle", in_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
